inst_cache: RTL and testbench
=============================

// Module: inst_cache
// PURPOSE
//  Responder side of the fetch interface: takes the fetch-stage PC each cycle and
//  returns InstrF plus Ihit. Ihit low stalls the PC register.
//  Direct-mapped, read-only instruction cache; misses refill one line word-by-word
//  from the instruction memory port. Sits between the fetch stage and main memory.
// PARAMETERS
//  SETS        16   number of lines (power of 2); index = PC[4+log2(SETS)-1:4]
//  LINE_WORDS  4    32-bit words per line (power of 2); offset = PC[3:2]
//  ADDR_W      32   byte-address width; tag = PC[ADDR_W-1:4+log2(SETS)]
// PORTS
//  clk        in   1   clock, all state on rising edge
//  reset      in   1   synchronous, active-high
//  PC         in   32  fetch address (bits [1:0] ignored)
//  ReqF       in   1   fetch request valid this cycle
//  Flush      in   1   invalidate all lines (one cycle)
//  InstrF     out  32  instruction word; valid when Ihit=1
//  Ihit       out  1   combinational hit: ReqF & state==IDLE & valid & tag match
//  MemReq     out  1   refill read request, held high for entire refill
//  MemAddr    out  32  word address of current refill beat (line base + beat*4)
//  MemRData   in   32  refill data
//  MemRValid  in   1   beat accepted/data valid; legal only while MemReq=1
// BEHAVIOUR
//  - Reset: all valid bits 0, state IDLE, beat=0, MemReq=0, MemAddr=0. Ihit=0 and
//    InstrF=0 while reset is high. Tag/data arrays are not cleared.
//  - States: IDLE, REFILL, COMMIT.
//  - IDLE: lookup is combinational, with zero-cycle hit latency (same cycle as PC).
//    On ReqF & miss: latch MissAddr = {PC[31:4],4'b0}, beat=0, go REFILL.
//    Ihit=0 in the miss cycle.
//  - REFILL: MemReq=1, MemAddr=MissAddr+beat*4. On MemRValid, write MemRData into
//    the line buffer at [beat] and increment beat. On the MemRValid with beat==
//    LINE_WORDS-1, go COMMIT. Back-to-back MemRValid is allowed (one word/cycle).
//    Ihit=0 throughout, regardless of PC.
//  - COMMIT (1 cycle): write the line buffer, tag, and valid=1 at index(MissAddr).
//    MemReq=0. Go IDLE. The next IDLE cycle re-looks-up the current PC.
//  - PC change during REFILL (redirect/mispredict): the refill of MissAddr still
//    completes and commits. The new PC is looked up afterwards, so a new miss
//    costs a fresh refill.
//  - Flush: in IDLE or COMMIT, clear all valid bits. Ihit=0 that cycle. If Flush
//    and COMMIT coincide, the line is not marked valid.
//  - Flush in REFILL: the refill continues, but its COMMIT leaves the line invalid.
//    The flush is sticky in a pending bit until COMMIT.
//  - Reset mid-REFILL: abort immediately. Next cycle MemReq=0, state IDLE, no
//    valid bits set. Late MemRValid is ignored.
//  - ReqF=0 in IDLE: Ihit=0 and no state change. InstrF is don't-care and is
//    driven from the array read.
//  - MemAddr[1:0] are always 0. Beat counter width is log2(LINE_WORDS); it wraps
//    only via the COMMIT transition.
// STRUCTURE
//  - icache_pkg holds: state enum typedef (IDLE/REFILL/COMMIT), localparams
//    OFFSET_W, INDEX_W, TAG_W, and the tag/index/offset extraction functions.
//  - One sub-module: icache_line_ram holds the SETSxLINE_WORDS data array.
//    Asynchronous read; full-line write with write-enable on COMMIT.
//  - Tag/valid arrays, FSM, line buffer, and beat counter live in inst_cache.
// TESTING
//  1. Cold miss: reset, then PC=0x00400000, ReqF=1 -> Ihit=0; MemReq=1 with
//     MemAddr 0x00400000..0x0040000C over 4 beats; COMMIT; next cycle Ihit=1 and
//     InstrF = beat-0 data.
//  2. Hit after fill: PC=0x00400008 -> Ihit=1 same cycle, InstrF = beat-2 data,
//     MemReq stays 0.
//  3. Conflict: PC=0x00400100 (same index 0, different tag) -> miss and refill.
//     Then PC=0x00400000 -> miss again (eviction).
//  4. Memory stalls: MemRValid pattern 1,0,0,1,1,0,1 -> exactly 4 words written
//     in order. MemAddr holds during gaps.
//  5. Redirect mid-refill: miss on 0x00400040; at beat 1 change PC to 0x00400000
//     (cached) -> Ihit=0 until COMMIT, then Ihit=1 for 0x00400000.
//     Line 0x00400040 is valid.
//  6. Flush during REFILL and reset at beat 2 -> line stays invalid and MemReq=0
//     the cycle after reset. A re-fetch of the same PC misses.

Source files
------------

// File: rtl/icache_pkg.sv
// Geometry, FSM state type and address-field helpers shared by the instruction cache.
package icache_pkg;
  localparam int SETS       = 16;
  localparam int LINE_WORDS = 4;
  localparam int ADDR_W     = 32;
  localparam int OFFSET_W   = $clog2(LINE_WORDS);
  localparam int INDEX_W    = $clog2(SETS);
  localparam int LINE_LSB   = OFFSET_W + 2;
  localparam int TAG_W      = ADDR_W - LINE_LSB - INDEX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    COMMIT = 2'd2
  } state_t;

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
    return addr[LINE_LSB +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] get_offset(input logic [ADDR_W-1:0] addr);
    return addr[2 +: OFFSET_W];
  endfunction
endpackage

// File: rtl/icache_line_ram.sv
// Cache data array: a whole line is written at once, one word is read asynchronously.
module icache_line_ram
  import icache_pkg::*;
(
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [INDEX_W-1:0]       i_widx,
  input  logic [LINE_WORDS*32-1:0] i_wline,
  input  logic [INDEX_W-1:0]       i_ridx,
  input  logic [OFFSET_W-1:0]      i_roff,
  output logic [31:0]              o_rdata
);
  logic [LINE_WORDS*32-1:0] r_mem [SETS];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_widx] <= i_wline;
  end

  assign o_rdata = r_mem[i_ridx][{i_roff, 5'b0} +: 32];
endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: zero-cycle hit lookup, word-by-word
// line refill from memory, then a one-cycle commit into the tag/valid/data arrays.
module inst_cache
  import icache_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic        ReqF,
  input  logic        Flush,
  output logic [31:0] InstrF,
  output logic        Ihit,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic [31:0] MemRData,
  input  logic        MemRValid
);
  state_t                   r_state;
  logic [SETS-1:0]          r_valid;
  logic [TAG_W-1:0]         r_tag [SETS];
  logic [ADDR_W-1:0]        r_miss_addr;
  logic [OFFSET_W-1:0]      r_beat;
  logic [LINE_WORDS*32-1:0] r_line_buf;
  logic                     r_flush_pend;

  logic [INDEX_W-1:0] w_idx;
  logic [INDEX_W-1:0] w_miss_idx;
  logic               w_tag_hit;
  logic               w_commit_we;
  logic [31:0]        w_rdata;

  assign w_idx       = get_index(PC);
  assign w_miss_idx  = get_index(r_miss_addr);
  assign w_tag_hit   = r_valid[w_idx] && (r_tag[w_idx] == get_tag(PC));
  assign Ihit        = ReqF && !reset && !Flush && (r_state == IDLE) && w_tag_hit;
  assign InstrF      = reset ? '0 : w_rdata;
  assign MemReq      = (r_state == REFILL);
  assign MemAddr     = r_miss_addr | {{(ADDR_W-OFFSET_W-2){1'b0}}, r_beat, 2'b00};
  assign w_commit_we = (r_state == COMMIT) && !reset;

  icache_line_ram u_line_ram (
    .clk     (clk),
    .i_we    (w_commit_we),
    .i_widx  (w_miss_idx),
    .i_wline (r_line_buf),
    .i_ridx  (w_idx),
    .i_roff  (get_offset(PC)),
    .o_rdata (w_rdata)
  );

  // IDLE: lookup / start miss | REFILL: collect beats | COMMIT: install line
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_valid      <= '0;
      r_miss_addr  <= '0;
      r_beat       <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Flush) begin
            r_valid <= '0;
          end else if (ReqF && !w_tag_hit) begin
            r_miss_addr  <= {PC[ADDR_W-1:LINE_LSB], {LINE_LSB{1'b0}}};
            r_beat       <= '0;
            r_flush_pend <= 1'b0;
            r_state      <= REFILL;
          end
        end
        REFILL: begin
          if (Flush) begin
            r_valid      <= '0;
            r_flush_pend <= 1'b1;
          end
          if (MemRValid) begin
            r_beat <= r_beat + 1'b1;
            if (r_beat == OFFSET_W'(LINE_WORDS-1)) r_state <= COMMIT;
          end
        end
        COMMIT: begin
          if (Flush) r_valid <= '0;
          else       r_valid[w_miss_idx] <= !r_flush_pend;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Arrays are never cleared; validity alone decides whether their contents count.
  always_ff @(posedge clk) begin
    if (r_state == REFILL && MemRValid) r_line_buf[{r_beat, 5'b0} +: 32] <= MemRData;
    if (w_commit_we) r_tag[w_miss_idx] <= get_tag(r_miss_addr);
  end
endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache against a per-line valid/tag model and a fixed memory image.
module tb_inst_cache;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] PC = '0;
  logic        ReqF = 1'b0;
  logic        Flush = 1'b0;
  logic [31:0] InstrF;
  logic        Ihit;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic [31:0] MemRData = '0;
  logic        MemRValid = 1'b0;

  int total = 0;
  int bad = 0;

  bit          m_valid [16];
  logic [31:0] m_tag   [16];

  logic [31:0] g_addr[$];
  bit          g_vld[$];
  logic [31:0] g_acc[$];
  bit          g_req_ok, g_ihit_seen, g_timeout;

  inst_cache dut (
    .clk(clk), .reset(reset), .PC(PC), .ReqF(ReqF), .Flush(Flush),
    .InstrF(InstrF), .Ihit(Ihit), .MemReq(MemReq), .MemAddr(MemAddr),
    .MemRData(MemRData), .MemRValid(MemRValid)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a >> 2;
    return (w * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a / 16) % 16);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[m_idx(a)] && (m_tag[m_idx(a)] == a / 256);
  endfunction

  function automatic void m_fill(input logic [31:0] a, input bit ok);
    m_valid[m_idx(a)] = ok;
    m_tag[m_idx(a)]   = a / 256;
  endfunction

  function automatic void m_flush();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endfunction

  // Memory responder for one refill; records what the DUT presented each cycle.
  task automatic serve(input logic [15:0] pat, input int plen, input int redir_beat,
                       input logic [31:0] redir_pc, input int flush_beat);
    int cyc = 0;
    bit fdone = 0;
    g_addr.delete(); g_vld.delete(); g_acc.delete();
    g_req_ok = 1; g_ihit_seen = 0; g_timeout = 0;
    while (g_acc.size() < 4) begin
      @(negedge clk);
      if (g_acc.size() == redir_beat) PC = redir_pc;
      Flush = (!fdone && g_acc.size() == flush_beat);
      if (Flush) fdone = 1;
      MemRValid = (cyc < plen) ? pat[cyc] : ($urandom_range(0, 2) != 0);
      MemRData = mem_word(MemAddr);
      #1;
      g_addr.push_back(MemAddr);
      g_vld.push_back(MemRValid);
      if (MemReq !== 1'b1) g_req_ok = 0;
      if (Ihit !== 1'b0) g_ihit_seen = 1;
      if (MemRValid) g_acc.push_back(MemAddr);
      cyc++;
      if (cyc > 60) begin g_timeout = 1; break; end
    end
    @(negedge clk);
    MemRValid = 1'b0;
    Flush = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) begin
      @(negedge clk);
      reset = 1'b1; ReqF = 1'b1; PC = 32'h0040_0000;
      #1;
      total++;
      if (Ihit !== 1'b0 || InstrF !== 32'h0 || MemReq !== 1'b0 || MemAddr !== 32'h0) begin
        bad++;
        $display("FAIL reset_outputs: Ihit=%b InstrF=%h MemReq=%b MemAddr=%h want 0/0/0/0", Ihit, InstrF, MemReq, MemAddr);
      end
    end
    m_flush();
    @(negedge clk);
    reset = 1'b0; ReqF = 1'b0;
    #1;
    total++;
    if (Ihit !== 1'b0 || MemReq !== 1'b0 || MemAddr !== 32'h0) begin
      bad++;
      $display("FAIL post_reset_idle: Ihit=%b MemReq=%b MemAddr=%h want 0/0/0", Ihit, MemReq, MemAddr);
    end
  endtask

  task automatic test_cold_miss();
    logic [31:0] a = 32'h0040_0000;
    @(negedge clk);
    PC = a; ReqF = 1'b1;
    #1;
    total++;
    if (Ihit !== 1'b0) begin bad++; $display("FAIL cold_miss_cycle: Ihit=%b want 0", Ihit); end
    serve(16'hFFFF, 16, -1, 32'h0, -1);
    total++;
    if (g_timeout || !g_req_ok || g_ihit_seen || g_acc.size() != 4) begin
      bad++;
      $display("FAIL cold_refill_ctl: timeout=%0b req_ok=%0b ihit_seen=%0b beats=%0d want 0/1/0/4", g_timeout, g_req_ok, g_ihit_seen, g_acc.size());
    end
    for (int k = 0; k < g_acc.size(); k++) begin
      total++;
      if (g_acc[k] !== a + 32'(4 * k)) begin
        bad++; $display("FAIL cold_refill_addr%0d: got=%h want=%h", k, g_acc[k], a + 32'(4 * k));
      end
    end
    #1;
    total++;
    if (Ihit !== 1'b0 || MemReq !== 1'b0) begin
      bad++; $display("FAIL cold_commit: Ihit=%b MemReq=%b want 0/0", Ihit, MemReq);
    end
    m_fill(a, 1'b1);
    @(negedge clk);
    #1;
    total++;
    if (Ihit !== 1'b1 || InstrF !== mem_word(a)) begin
      bad++; $display("FAIL cold_first_hit: Ihit=%b InstrF=%h want 1/%h", Ihit, InstrF, mem_word(a));
    end
  endtask

  task automatic test_hit();
    logic [31:0] offs [3] = '{32'h8, 32'hC, 32'h4};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      PC = 32'h0040_0000 + offs[i]; ReqF = 1'b1;
      #1;
      total++;
      if (Ihit !== m_hit(PC) || InstrF !== mem_word(PC) || MemReq !== 1'b0) begin
        bad++;
        $display("FAIL hit_word%0d: Ihit=%b InstrF=%h MemReq=%b want %b/%h/0", i, Ihit, InstrF, MemReq, m_hit(PC), mem_word(PC));
      end
    end
  endtask

  task automatic test_conflict();
    logic [31:0] lines [2] = '{32'h0040_0100, 32'h0040_0000};
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      PC = lines[j]; ReqF = 1'b1;
      #1;
      total++;
      if (Ihit !== 1'b0 || m_hit(PC)) begin
        bad++; $display("FAIL conflict_miss%0d: Ihit=%b model_hit=%b want 0/0", j, Ihit, m_hit(PC));
      end
      serve(16'($urandom), 16, -1, 32'h0, -1);
      for (int k = 0; k < g_acc.size(); k++) begin
        total++;
        if (g_acc[k] !== lines[j] + 32'(4 * k)) begin
          bad++; $display("FAIL conflict_addr%0d_%0d: got=%h want=%h", j, k, g_acc[k], lines[j] + 32'(4 * k));
        end
      end
      total++;
      if (g_timeout || !g_req_ok || g_acc.size() != 4) begin
        bad++; $display("FAIL conflict_refill%0d: timeout=%0b req_ok=%0b beats=%0d", j, g_timeout, g_req_ok, g_acc.size());
      end
      m_fill(lines[j], 1'b1);
    end
    @(negedge clk);
    PC = 32'h0040_000C;
    #1;
    total++;
    if (Ihit !== 1'b1 || InstrF !== mem_word(PC)) begin
      bad++; $display("FAIL conflict_refetch: Ihit=%b InstrF=%h want 1/%h", Ihit, InstrF, mem_word(PC));
    end
  endtask

  task automatic test_mem_stall();
    logic [31:0] a = 32'h0040_0020;
    @(negedge clk);
    PC = a; ReqF = 1'b1;
    #1;
    serve(16'h0059, 7, -1, 32'h0, -1);
    total++;
    if (g_addr.size() != 7 || g_acc.size() != 4) begin
      bad++; $display("FAIL stall_cycles: cycles=%0d beats=%0d want 7/4", g_addr.size(), g_acc.size());
    end
    for (int i = 1; i < g_addr.size(); i++) begin
      if (!g_vld[i-1]) begin
        total++;
        if (g_addr[i] !== g_addr[i-1]) begin
          bad++; $display("FAIL stall_hold%0d: got=%h want=%h", i, g_addr[i], g_addr[i-1]);
        end
      end
    end
    for (int k = 0; k < g_acc.size(); k++) begin
      total++;
      if (g_acc[k] !== a + 32'(4 * k)) begin
        bad++; $display("FAIL stall_addr%0d: got=%h want=%h", k, g_acc[k], a + 32'(4 * k));
      end
    end
    m_fill(a, 1'b1);
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      PC = a + 32'(4 * w);
      #1;
      total++;
      if (Ihit !== 1'b1 || InstrF !== mem_word(PC)) begin
        bad++; $display("FAIL stall_word%0d: Ihit=%b InstrF=%h want 1/%h", w, Ihit, InstrF, mem_word(PC));
      end
    end
  endtask

  task automatic test_redirect();
    logic [31:0] a = 32'h0040_0040;
    logic [31:0] r = 32'h0040_0000;
    @(negedge clk);
    PC = a; ReqF = 1'b1;
    #1;
    serve(16'hFFFF, 16, 1, r, -1);
    total++;
    if (g_ihit_seen || g_acc.size() != 4 || g_acc[0] !== a || g_acc[3] !== a + 32'hC) begin
      bad++; $display("FAIL redirect_refill: ihit_seen=%0b beats=%0d want 0/4 at base %h", g_ihit_seen, g_acc.size(), a);
    end
    #1;
    total++;
    if (Ihit !== 1'b0) begin bad++; $display("FAIL redirect_commit: Ihit=%b want 0", Ihit); end
    m_fill(a, 1'b1);
    @(negedge clk);
    #1;
    total++;
    if (Ihit !== m_hit(r) || InstrF !== mem_word(r)) begin
      bad++; $display("FAIL redirect_new_pc: Ihit=%b InstrF=%h want %b/%h", Ihit, InstrF, m_hit(r), mem_word(r));
    end
    @(negedge clk);
    PC = a + 32'h4;
    #1;
    total++;
    if (Ihit !== 1'b1 || InstrF !== mem_word(PC)) begin
      bad++; $display("FAIL redirect_old_line: Ihit=%b InstrF=%h want 1/%h", Ihit, InstrF, mem_word(PC));
    end
  endtask

  task automatic test_flush();
    logic [31:0] a = 32'h0040_00C0;
    logic [31:0] b = 32'h0040_00D0;
    @(negedge clk);
    PC = a; ReqF = 1'b1;
    #1;
    serve(16'hFFFF, 16, -1, 32'h0, 1);
    m_flush();
    m_fill(a, 1'b0);
    @(negedge clk);
    #1;
    total++;
    if (Ihit !== 1'b0 || m_hit(a)) begin
      bad++; $display("FAIL flush_refill_invalid: Ihit=%b want 0", Ihit);
    end
    serve(16'hFFFF, 16, -1, 32'h0, -1);
    m_fill(a, 1'b1);
    @(negedge clk);
    #1;
    total++;
    if (Ihit !== 1'b1 || InstrF !== mem_word(a)) begin
      bad++; $display("FAIL flush_refetch_hit: Ihit=%b InstrF=%h want 1/%h", Ihit, InstrF, mem_word(a));
    end
    @(negedge clk);
    PC = b;
    #1;
    serve(16'hFFFF, 16, -1, 32'h0, -1);
    Flush = 1'b1;
    #1;
    total++;
    if (Ihit !== 1'b0) begin bad++; $display("FAIL flush_commit_cycle: Ihit=%b want 0", Ihit); end
    m_flush();
    @(negedge clk);
    Flush = 1'b0; PC = a;
    #1;
    total++;
    if (Ihit !== 1'b0 || m_hit(a)) begin
      bad++; $display("FAIL flush_commit_clears: Ihit=%b want 0", Ihit);
    end
    serve(16'($urandom), 16, -1, 32'h0, -1);
    m_fill(a, 1'b1);
  endtask

  task automatic test_reset_abort();
    logic [31:0] a = 32'h0040_0080;
    @(negedge clk);
    PC = a; ReqF = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      Flush = (k == 0); MemRValid = 1'b1; MemRData = mem_word(MemAddr);
      #1;
      total++;
      if (MemReq !== 1'b1 || MemAddr !== a + 32'(4 * k)) begin
        bad++; $display("FAIL abort_beat%0d: MemReq=%b MemAddr=%h want 1/%h", k, MemReq, MemAddr, a + 32'(4 * k));
      end
    end
    @(negedge clk);
    Flush = 1'b0; reset = 1'b1;
    #1;
    total++;
    if (Ihit !== 1'b0 || InstrF !== 32'h0) begin
      bad++; $display("FAIL abort_reset_cycle: Ihit=%b InstrF=%h want 0/0", Ihit, InstrF);
    end
    m_flush();
    @(negedge clk);
    reset = 1'b0; ReqF = 1'b0;
    #1;
    total++;
    if (MemReq !== 1'b0 || MemAddr !== 32'h0 || Ihit !== 1'b0) begin
      bad++; $display("FAIL abort_after_reset: MemReq=%b MemAddr=%h Ihit=%b want 0/0/0", MemReq, MemAddr, Ihit);
    end
    @(negedge clk);
    MemRValid = 1'b0; ReqF = 1'b1;
    #1;
    total++;
    if (Ihit !== 1'b0 || MemReq !== 1'b0) begin
      bad++; $display("FAIL abort_refetch_miss: Ihit=%b MemReq=%b want 0/0", Ihit, MemReq);
    end
    serve(16'hFFFF, 16, -1, 32'h0, -1);
    total++;
    if (g_acc.size() != 4 || g_acc[0] !== a || g_timeout) begin
      bad++; $display("FAIL abort_refill_restart: beats=%0d timeout=%0b want 4/0 from %h", g_acc.size(), g_timeout, a);
    end
    m_fill(a, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (Ihit !== 1'b0 || InstrF !== 32'h0) begin
      bad++; $display("FAIL reset_gates_hit: Ihit=%b InstrF=%h want 0/0", Ihit, InstrF);
    end
    m_flush();
    @(negedge clk);
    reset = 1'b0; ReqF = 1'b0;
    #1;
  endtask

  task automatic test_random();
    logic [31:0] base;
    int fb;
    for (int it = 0; it < 80; it++) begin
      @(negedge clk);
      PC = 32'h0040_0000 + ($urandom_range(0, 2) << 8) + ($urandom_range(0, 3) << 4) + $urandom_range(0, 15);
      Flush = ($urandom_range(0, 9) == 0);
      ReqF = Flush ? 1'b0 : ($urandom_range(0, 3) != 0);
      #1;
      total++;
      if (Ihit !== (ReqF && m_hit(PC)) || MemReq !== 1'b0) begin
        bad++; $display("FAIL rand_lookup%0d: pc=%h Ihit=%b MemReq=%b want %b/0", it, PC, Ihit, MemReq, ReqF && m_hit(PC));
      end
      if (Ihit === 1'b1) begin
        total++;
        if (InstrF !== mem_word(PC)) begin
          bad++; $display("FAIL rand_data%0d: pc=%h got=%h want=%h", it, PC, InstrF, mem_word(PC));
        end
      end
      if (Flush) begin
        m_flush();
      end else if (ReqF && !m_hit(PC)) begin
        base = PC & ~32'hF;
        fb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
        serve(16'($urandom), 16, -1, 32'h0, fb);
        for (int k = 0; k < g_acc.size(); k++) begin
          total++;
          if (g_acc[k] !== base + 32'(4 * k)) begin
            bad++; $display("FAIL rand_addr%0d_%0d: got=%h want=%h", it, k, g_acc[k], base + 32'(4 * k));
          end
        end
        Flush = ($urandom_range(0, 4) == 0);
        #1;
        total++;
        if (Ihit !== 1'b0 || g_timeout || !g_req_ok || g_ihit_seen) begin
          bad++; $display("FAIL rand_refill%0d: Ihit=%b timeout=%0b req_ok=%0b ihit_seen=%0b", it, Ihit, g_timeout, g_req_ok, g_ihit_seen);
        end
        if (Flush || fb >= 0) m_flush();
        else m_fill(base, 1'b1);
      end
    end
    @(negedge clk);
    Flush = 1'b0; ReqF = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_mem_stall();
    test_redirect();
    test_flush();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
